// File: rtl/pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : pwm_pkg                                                  |
// | Description : Shared definitions for the 8-bit, 256-tick PWM generator |
// |               and its receive-side decoder: level width, nominal       |
// |               period, decoder state encoding, level typedef and the    |
// |               high-time to level mapping.                              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package pwm_pkg;

  localparam int PWM_LEVEL_W   = 8;
  localparam int PWM_PERIOD    = 256;
  localparam int PWM_LEVEL_MAX = (1 << PWM_LEVEL_W) - 1;

  typedef logic [PWM_LEVEL_W-1:0] pwm_level_t;

  typedef enum logic [0:0] {
    ACQUIRE = 1'b0,
    MEASURE = 1'b1
  } pwm_state_e;

  // The generator drives high for level+1 ticks, so a high time of h cycles
  // decodes to h-1. h=0 cannot occur in a measured period but is clamped to
  // 0 rather than wrapping; anything above the maximum level saturates.
  function automatic pwm_level_t pwm_clamp_level(input int unsigned h);
    if (h == 0) begin
      return '0;
    end else if ((h - 32'd1) > 32'(PWM_LEVEL_MAX)) begin
      return pwm_level_t'(PWM_LEVEL_MAX);
    end else begin
      return pwm_level_t'(h - 32'd1);
    end
  endfunction

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_in_sync.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : pwm_in_sync                                              |
// | Description : Two-flop synchronizer for the asynchronous PWM line plus |
// |               a delay flop used for rising-edge detection.             |
// | Ports       : clk      - system clock                                  |
// |               rst_n    - asynchronous active-low reset                 |
// |               async_in - raw asynchronous input line                   |
// |               s        - synchronized line                             |
// |               rise     - single-cycle strobe on a 0->1 transition of s |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module pwm_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic s,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= async_in;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign s    = r_sync;
  assign rise = r_sync & ~r_sync_d;

endmodule : pwm_in_sync
`default_nettype wire

// File: rtl/pwm_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : pwm_decoder                                              |
// | Description : Recovers the 8-bit level from a 256-tick PWM waveform by |
// |               measuring high time and rise-to-rise period. Flags a     |
// |               constant-high line, a dead line and a bad period.        |
// | Ports       : clk        - system clock (one PWM tick per cycle)       |
// |               rst_n      - asynchronous active-low reset               |
// |               pwm_in     - asynchronous PWM input line                 |
// |               level      - last decoded level                          |
// |               valid      - one-cycle strobe when level is updated      |
// |               locked     - last completed period within tolerance      |
// |               period_err - last completed period out of tolerance      |
// |               stuck_high - line high beyond timeout (level = 255)      |
// |               no_signal  - line low beyond timeout (level = 0)         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int PERIOD = PWM_PERIOD,
  parameter int TOL    = 4,
  parameter int CNT_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pwm_in,
  output logic [PWM_LEVEL_W-1:0] level,
  output logic                   valid,
  output logic                   locked,
  output logic                   period_err,
  output logic                   stuck_high,
  output logic                   no_signal
);

  localparam int TMO = PERIOD + TOL + 1;

  localparam logic [CNT_W-1:0] c_tmo   = CNT_W'(TMO);
  localparam logic [CNT_W-1:0] c_p_min = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] c_p_max = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  localparam logic [0:0] c_st_acquire = ACQUIRE;
  localparam logic [0:0] c_st_measure = MEASURE;

  // The counters saturate at TMO, so CNT_W must be able to represent it.
  generate
    if (TMO >= (1 << CNT_W)) begin : g_cnt_w_too_small
      $error("pwm_decoder: CNT_W too small to hold PERIOD+TOL+1");
    end
  endgenerate

  // ----------------------------------------------------------------------
  // Input conditioning
  // ----------------------------------------------------------------------
  logic w_s;
  logic w_rise;

  pwm_in_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pwm_in),
    .s        (w_s),
    .rise     (w_rise)
  );

  // ----------------------------------------------------------------------
  // Period / high-time counters and timeout
  // ----------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt_p;
  logic [CNT_W-1:0] r_cnt_h;
  logic             r_tmo_armed;
  logic             w_tmo;
  logic             w_p_good;
  pwm_level_t       w_level_dec;

  // The counter parks at TMO; the armed bit makes the timeout a single
  // event per silent stretch. A rise in the same cycle wins over timeout.
  assign w_tmo       = (r_cnt_p == c_tmo) && r_tmo_armed;
  assign w_p_good    = (r_cnt_p >= c_p_min) && (r_cnt_p <= c_p_max);
  assign w_level_dec = pwm_clamp_level(32'(r_cnt_h));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_p     <= '0;
      r_cnt_h     <= '0;
      r_tmo_armed <= 1'b1;
    end else begin
      if (w_rise) begin
        r_cnt_p <= c_one;
      end else if (r_cnt_p != c_tmo) begin
        r_cnt_p <= r_cnt_p + c_one;
      end

      // The rise cycle itself has s=1, hence the load of 1.
      if (w_rise) begin
        r_cnt_h <= c_one;
      end else if (w_s && (r_cnt_h != c_tmo)) begin
        r_cnt_h <= r_cnt_h + c_one;
      end

      if (w_rise) begin
        r_tmo_armed <= 1'b1;
      end else if (w_tmo) begin
        r_tmo_armed <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------------------
  // FSM and output registers
  // ----------------------------------------------------------------------
  logic [0:0]  r_state;
  pwm_level_t  r_level;
  logic        r_valid;
  logic        r_locked;
  logic        r_period_err;
  logic        r_stuck_high;
  logic        r_no_signal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_st_acquire;
      r_level      <= '0;
      r_valid      <= 1'b0;
      r_locked     <= 1'b0;
      r_period_err <= 1'b0;
      r_stuck_high <= 1'b0;
      r_no_signal  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_rise) begin
        // In ACQUIRE there is no complete period yet; just start measuring.
        if (r_state == c_st_measure) begin
          if (w_p_good) begin
            r_level      <= w_level_dec;
            r_valid      <= 1'b1;
            r_locked     <= 1'b1;
            r_period_err <= 1'b0;
            r_stuck_high <= 1'b0;
            r_no_signal  <= 1'b0;
          end else begin
            r_locked     <= 1'b0;
            r_period_err <= 1'b1;
          end
        end
        r_state <= c_st_measure;
      end else if (w_tmo) begin
        r_level      <= w_s ? pwm_level_t'(PWM_LEVEL_MAX) : '0;
        r_valid      <= 1'b1;
        r_locked     <= 1'b0;
        r_stuck_high <= w_s;
        r_no_signal  <= ~w_s;
        r_state      <= c_st_acquire;
      end
    end
  end

  assign level      = r_level;
  assign valid      = r_valid;
  assign locked     = r_locked;
  assign period_err = r_period_err;
  assign stuck_high = r_stuck_high;
  assign no_signal  = r_no_signal;

endmodule : pwm_decoder
`default_nettype wire

// File: tb/tb_pwm_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_pwm_decoder                                           |
// | Description : Directed self-checking bench for pwm_decoder, driving a  |
// |               behavioural PWM generator on pwm_in.                     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_pwm_decoder;

  logic       clk;
  logic       rst_n;
  logic       pwm_in;
  logic [7:0] level;
  logic       valid;
  logic       locked;
  logic       period_err;
  logic       stuck_high;
  logic       no_signal;

  int total;
  int bad;

  // Generator control: mode 0 = low, 1 = PWM, 2 = constant high.
  // next_* values take effect at the start of a generator period.
  int next_mode;
  int next_period;
  int next_high;
  int gen_mode;
  int gen_period;
  int gen_high;
  int gen_tick;

  bit prev_valid;
  bit dbl_valid;

  pwm_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .level      (level),
    .valid      (valid),
    .locked     (locked),
    .period_err (period_err),
    .stuck_high (stuck_high),
    .no_signal  (no_signal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    pwm_in     = 1'b0;
    gen_mode   = 0;
    gen_period = 256;
    gen_high   = 1;
    gen_tick   = 0;
    forever begin
      @(negedge clk);
      if (gen_tick == 0) begin
        gen_mode   = next_mode;
        gen_period = next_period;
        gen_high   = next_high;
      end
      case (gen_mode)
        1:       pwm_in = (gen_tick < gen_high);
        2:       pwm_in = 1'b1;
        default: pwm_in = 1'b0;
      endcase
      if (gen_mode != 1 || gen_tick >= gen_period - 1) gen_tick = 0;
      else gen_tick = gen_tick + 1;
    end
  end

  initial begin
    prev_valid = 1'b0;
    dbl_valid  = 1'b0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && prev_valid) dbl_valid = 1'b1;
      prev_valid = (valid === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(input int max_cyc, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n = n + 1;
      if (valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({level, valid, locked, period_err, stuck_high, no_signal} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {level, valid, locked, period_err, stuck_high, no_signal});
    end
  endtask

  task automatic test_no_signal;
    int n;
    bit seen;
    rst_n = 1'b1;
    wait_valid(400, n, seen);
    total++;
    if (!(seen && n >= 259 && n <= 264)) begin
      bad++;
      $display("FAIL nosig_timing: seen=%0d cycles=%0d want ~262", seen, n);
    end
    total++;
    if ({no_signal, stuck_high, locked} !== 3'b100) begin
      bad++;
      $display("FAIL nosig_flags: got ns/sh/lk=%b want 100", {no_signal, stuck_high, locked});
    end
    total++;
    if (level !== 8'h00) begin
      bad++;
      $display("FAIL nosig_level: got %h want 00", level);
    end
    wait_valid(600, n, seen);
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL nosig_quiet: extra valid after %0d cycles, want none", n);
    end
  endtask

  task automatic test_lock;
    int n;
    bit seen;
    next_period = 256;
    next_high   = 129;
    next_mode   = 1;
    wait_valid(600, n, seen);
    total++;
    if (!(seen && n >= 256 && n <= 264)) begin
      bad++;
      $display("FAIL lock_first_valid: seen=%0d cycles=%0d want second rise ~259", seen, n);
    end
    total++;
    if ({level, locked, period_err, no_signal} !== {8'h80, 3'b100}) begin
      bad++;
      $display("FAIL lock_80: got lvl=%h lk=%b pe=%b ns=%b want 80 1 0 0",
               level, locked, period_err, no_signal);
    end
    wait_valid(300, n, seen);
    total++;
    if (!(seen && n == 256 && level === 8'h80)) begin
      bad++;
      $display("FAIL lock_repeat: seen=%0d cycles=%0d lvl=%h want 256 80", seen, n, level);
    end
  endtask

  task automatic test_levels;
    int lv[3];
    int n;
    bit seen;
    lv[0] = 0;
    lv[1] = 1;
    lv[2] = 254;
    for (int i = 0; i < 3; i++) begin
      next_high = lv[i] + 1;
      wait_valid(300, n, seen);
      wait_valid(300, n, seen);
      total++;
      if (!(seen && n == 256 && level === 8'(lv[i]))) begin
        bad++;
        $display("FAIL level_%0d: seen=%0d cycles=%0d got %h want %h",
                 lv[i], seen, n, level, 8'(lv[i]));
      end
    end
  endtask

  task automatic test_stuck_high;
    int n;
    bit seen;
    next_mode = 2;
    wait_valid(300, n, seen);
    total++;
    if (!(seen && level === 8'hFE)) begin
      bad++;
      $display("FAIL stuck_last_rise: seen=%0d got %h want fe", seen, level);
    end
    wait_valid(400, n, seen);
    total++;
    if (!(seen && n == 261)) begin
      bad++;
      $display("FAIL stuck_timing: seen=%0d cycles=%0d want 261", seen, n);
    end
    total++;
    if ({level, stuck_high, locked, no_signal} !== {8'hFF, 3'b100}) begin
      bad++;
      $display("FAIL stuck_flags: got lvl=%h sh=%b lk=%b ns=%b want ff 1 0 0",
               level, stuck_high, locked, no_signal);
    end
    wait_valid(400, n, seen);
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL stuck_once: extra valid after %0d cycles, want none", n);
    end
    next_period = 256;
    next_high   = 17;
    next_mode   = 1;
    wait_valid(700, n, seen);
    total++;
    if (!(seen && n >= 500 && n <= 530)) begin
      bad++;
      $display("FAIL stuck_recover_timing: seen=%0d cycles=%0d want ~515", seen, n);
    end
    total++;
    if ({level, stuck_high, locked} !== {8'h10, 2'b01}) begin
      bad++;
      $display("FAIL stuck_recover: got lvl=%h sh=%b lk=%b want 10 0 1", level, stuck_high, locked);
    end
  endtask

  task automatic test_period_err;
    int n;
    bit seen;
    next_period = 200;
    next_high   = 100;
    wait_valid(300, n, seen);
    total++;
    if (!(seen && level === 8'h10)) begin
      bad++;
      $display("FAIL perr_boundary: seen=%0d got %h want 10", seen, level);
    end
    wait_valid(700, n, seen);
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL perr_no_valid: valid after %0d cycles, want none", n);
    end
    total++;
    if ({level, period_err, locked} !== {8'h10, 2'b10}) begin
      bad++;
      $display("FAIL perr_flags: got lvl=%h pe=%b lk=%b want 10 1 0", level, period_err, locked);
    end
    next_period = 256;
    next_high   = 65;
    wait_valid(700, n, seen);
    total++;
    if (!(seen && level === 8'h40 && period_err === 1'b0 && locked === 1'b1)) begin
      bad++;
      $display("FAIL perr_recover: seen=%0d lvl=%h pe=%b lk=%b want 40 0 1",
               seen, level, period_err, locked);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit seen;
    next_high = 129;
    wait_valid(300, n, seen);
    wait_valid(300, n, seen);
    total++;
    if (!(seen && level === 8'h80 && locked === 1'b1)) begin
      bad++;
      $display("FAIL rmid_pre: seen=%0d lvl=%h lk=%b want 80 1", seen, level, locked);
    end
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({level, valid, locked, period_err, stuck_high, no_signal} !== 13'd0) begin
      bad++;
      $display("FAIL rmid_async_clear: got %h want 0",
               {level, valid, locked, period_err, stuck_high, no_signal});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(700, n, seen);
    total++;
    if (!(seen && n >= 300 && n <= 520)) begin
      bad++;
      $display("FAIL rmid_two_rises: seen=%0d cycles=%0d want 300..520", seen, n);
    end
    total++;
    if ({level, locked} !== {8'h80, 1'b1}) begin
      bad++;
      $display("FAIL rmid_level: got lvl=%h lk=%b want 80 1", level, locked);
    end
  endtask

  task automatic test_valid_pulse;
    total++;
    if (dbl_valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_pulse: got two-cycle valid=%b want 0", dbl_valid);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    next_mode   = 0;
    next_period = 256;
    next_high   = 1;
    test_reset();
    test_no_signal();
    test_lock();
    test_levels();
    test_stuck_high();
    test_period_err();
    test_reset_mid();
    test_valid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pwm_decoder
`default_nettype wire

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
Receive-side counterpart of the team's 8-bit, 256-tick PWM generator. It samples an external PWM line, measures the high time and the period between rising edges, and recovers the 8-bit level that produced the waveform. It also detects a constant-high line (level 255), a dead line, and a wrong period. It sits between a board input pin and any logic that consumes a level, such as LED mirroring or servo/ADC-style readback.

Parameters:
PERIOD, 256, nominal PWM period in clk cycles (one tick per clk)
TOL, 4, allowed |measured period - PERIOD| in cycles for a period to count as good
CNT_W, 10, counter width; must hold PERIOD+TOL+1 (localparam-checked)

Ports:
clk  in  1  system clock; the generator runs on the same frequency
rst_n  in  1  asynchronous active-low reset
pwm_in  in  1  asynchronous PWM input line
level  out  8  last decoded level
valid  out  1  one-cycle strobe when level is updated
locked  out  1  last completed period was within tolerance
period_err  out  1  last completed period was out of tolerance
stuck_high  out  1  line held high beyond timeout (level reported as 255)
no_signal  out  1  line held low beyond timeout (level reported as 0)

Behaviour:
- Reset (async assert, sync release): all outputs 0; synchronizer flops 0; counters 0; state ACQUIRE.
- Input conditioning:
  - Two-flop synchronizer produces s; a further flop produces s_d.
  - rise = s & ~s_d.
- Counters (each CNT_W wide, saturating at TMO = PERIOD+TOL+1):
  - cnt_p: cycles since the last rise. Loads 1 on the rise cycle, otherwise increments.
  - cnt_h: cycles with s=1 since the last rise. Loads 1 on the rise cycle, otherwise increments when s=1.
- FSM states:
  - ACQUIRE: on rise, load both counters and go to MEASURE. No valid is produced (no complete period exists yet).
  - MEASURE, on rise: evaluate P=cnt_p and H=cnt_h using their pre-load values, then reload both counters.
    - If PERIOD-TOL <= P <= PERIOD+TOL: level <= min(H-1, 255); valid pulses; locked=1; period_err=0; stuck_high=0; no_signal=0.
    - Otherwise: period_err=1; locked=0; level is held; no valid.
  - Timeout, in either state, when cnt_p reaches TMO (fires once, since the counter saturates):
    - If s=1: level=255, stuck_high=1, no_signal=0, locked=0; valid pulses once.
    - If s=0: level=0, no_signal=1, stuck_high=0, locked=0; valid pulses once.
    - State goes to ACQUIRE.
    - After reset the timeout is armed, so a line dead from reset reports no_signal.
- Mapping rule: the generator drives high for level+1 ticks of 256.
  - H=1 decodes to 0.
  - H=255 decodes to 254.
  - Level 255 never produces edges and is reported only through stuck_high.
  - H=0 is impossible in MEASURE; if H-1 underflows, clamp to 0.
- Latency: level/valid register on the clk edge after the rise cycle. That is 3 clk edges after the first edge that samples pwm_in high (2 sync + 1 output register).
- Simultaneous events: a rise in the same cycle as timeout gives rise priority (evaluate P=TMO, which is out of tolerance → period_err).
- Output holding rules:
  - Flags and level hold between events.
  - valid is never high for two consecutive cycles.
- Reset mid-operation: outputs clear immediately. The first valid after release needs two rises, or a timeout.
- Glitches are not filtered; a spurious rise is reported as period_err.

Decomposition:
- Shared package pwm_pkg:
  - PWM_LEVEL_W=8
  - PWM_PERIOD=256
  - state enum {ACQUIRE, MEASURE}
  - the level typedef shared with the generator
- One natural sub-module: pwm_in_sync (2-flop synchronizer + s_d register + rise output, async active-low reset).
- Counters, FSM and output registers stay in pwm_decoder.

Test Plan:
- Generator at level 0x80, period 256 → no valid on the first rise; valid at the second rise with level=0x80, locked=1; then valid every 256 cycles.
- Levels 0, 1 and 254 in sequence → decoded 0x00, 0x01, 0xFE, each within one period + 3 cycles of the level change settling.
- Level switched to 255 (constant high) → 261 cycles after the last rise: level=0xFF, stuck_high=1, locked=0, exactly one valid; switching back to 0x10 → stuck_high clears, valid with 0x10 at the second rise.
- pwm_in held 0 from reset release → at cycle 261: no_signal=1, level=0, one valid, no further valids while the line stays low.
- Line with period 200 (high 100) → period_err=1, locked=0, no valid, level held; then period 256 at level 0x40 → period_err=0, valid with 0x40.
- rst_n pulsed low mid-period while locked at 0x80 → all outputs 0 within the same cycle (async); after release, first valid only after two rises, and it reads 0x80.
